// File: rtl/ps2_cmd_arbiter.sv
// ps2_cmd_arbiter
// Arbitrates PS/2 command bytes from two requesters (0 = init sequencer,
// 1 = UI) onto a single PS/2 transmitter. Each accepted command is sent,
// the transmitter ack is awaited, then the device reply is awaited. A resend
// request (0xFE from the device or a transmitter error) repeats the same byte
// up to MAX_RETRY times. Every accepted command ends in exactly one resp_valid
// pulse carrying OK, FAIL or TIMEOUT. Received bytes that are not the
// command reply are passed straight through to the stream output.
//
// Ports
//   clk, rst_n             system clock (rising edge), async active-low reset
//   req_valid[1:0]         per-requester command request
//   req_data0, req_data1   command byte for requester 0 / 1
//   req_ready[1:0]         one-cycle accept strobe per requester
//   resp_valid             one-cycle completion pulse
//   resp_id                requester owning the completion
//   resp_status[1:0]       00 OK, 01 FAIL, 10 TIMEOUT
//   tx_data, tx_start      byte and start pulse to the PS/2 transmitter
//   tx_busy/tx_ack/tx_error transmitter status (ack/error held until next start)
//   rx_data, rx_ready      byte and valid pulse from the PS/2 receiver
//   stream_data/valid      pass-through of received non-reply bytes
//   busy                   high whenever a command is in flight
module ps2_cmd_arbiter #(
  parameter int TIMEOUT_CYCLES = 540000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       resp_valid,
  output logic       resp_id,
  output logic [1:0] resp_status,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic       tx_ack,
  input  logic       tx_error,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] stream_data,
  output logic       stream_valid,
  output logic       busy
);

  localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);
  localparam logic [31:0]        TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES);

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_FAIL    = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_FAIL   = 8'hFC;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_TX,
    WAIT_ACK,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [31:0]          timer_q, timer_d;
  logic [1:0]           status_q, status_d;
  logic                 first_q, first_d;

  logic [1:0]           ready_c;
  logic                 consume;
  logic                 resend;
  logic                 win;
  logic                 rx_is_reply;

  assign rx_is_reply = (rx_data == BYTE_ACK) || (rx_data == BYTE_FAIL) ||
                       (rx_data == BYTE_RESEND);

  // State and datapath registers. last_grant resets to 1 so that requester 0
  // wins the very first contested arbitration after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tx_data_q    <= 8'h00;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      retry_q      <= '0;
      timer_q      <= 32'd0;
      status_q     <= STATUS_OK;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      status_q     <= status_d;
      first_q      <= first_d;
    end
  end

  // Next-state logic. A resend request raised in WAIT_TX or WAIT_ACK is
  // resolved once at the bottom so both sources share the retry budget.
  // In WAIT_ACK a reply byte takes priority over an expiring timer.
  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    retry_d      = retry_q;
    timer_d      = timer_q;
    status_d     = status_q;
    first_d      = first_q;
    ready_c      = 2'b00;
    consume      = 1'b0;
    resend       = 1'b0;
    win          = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready_c   = win ? 2'b10 : 2'b01;
          tx_data_d = win ? req_data1 : req_data0;
          grant_d   = win;
          retry_d   = '0;
          state_d   = START;
        end
      end

      START: begin
        timer_d = TIMEOUT_LOAD;
        first_d = 1'b1;
        state_d = WAIT_TX;
      end

      // tx_busy may not have risen yet in the first cycle after the start
      // pulse, and ack/error still hold the previous attempt's level.
      WAIT_TX: begin
        first_d = 1'b0;
        timer_d = timer_q - 32'd1;
        if (!first_q && !tx_busy && tx_ack) begin
          state_d = WAIT_ACK;
        end else if (!first_q && !tx_busy && tx_error) begin
          resend = 1'b1;
        end else if (timer_q <= 32'd1) begin
          status_d = STATUS_TIMEOUT;
          state_d  = RESP;
        end
      end

      WAIT_ACK: begin
        timer_d = timer_q - 32'd1;
        if (rx_ready && rx_is_reply) begin
          consume = 1'b1;
          if (rx_data == BYTE_ACK) begin
            status_d = STATUS_OK;
            state_d  = RESP;
          end else if (rx_data == BYTE_FAIL) begin
            status_d = STATUS_FAIL;
            state_d  = RESP;
          end else begin
            resend = 1'b1;
          end
        end else if (timer_q <= 32'd1) begin
          status_d = STATUS_TIMEOUT;
          state_d  = RESP;
        end
      end

      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (resend) begin
      if (retry_q < RETRY_LIMIT) begin
        retry_d = retry_q + 1'b1;
        state_d = START;
      end else begin
        status_d = STATUS_FAIL;
        state_d  = RESP;
      end
    end
  end

  assign tx_start    = (state_q == START);
  assign resp_valid  = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign resp_id     = grant_q;
  assign resp_status = status_q;
  assign tx_data     = tx_data_q;

  // These outputs follow inputs combinationally, so they are forced low
  // while reset is held to keep the reset output values independent of clk.
  assign req_ready    = rst_n ? ready_c : 2'b00;
  assign stream_valid = rst_n & rx_ready & ~consume;
  assign stream_data  = stream_valid ? rx_data : 8'h00;

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Testbench for ps2_cmd_arbiter. Drives inputs one time unit after the rising
// edge and samples DUT outputs on the falling edge through a monitor.
// Expected results come from a reference model that walks a per-attempt
// outcome plan and from round-robin bookkeeping of the last winner.
module tb_ps2_cmd_arbiter;

  localparam int TO = 100;
  localparam int MR = 2;

  localparam int O_FA     = 0;
  localparam int O_FC     = 1;
  localparam int O_FE     = 2;
  localparam int O_TXERR  = 3;
  localparam int O_SILENT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [7:0] req_data0, req_data1;
  logic [1:0] req_ready;
  logic       resp_valid, resp_id;
  logic [1:0] resp_status;
  logic [7:0] tx_data;
  logic       tx_start, tx_busy, tx_ack, tx_error;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] stream_data;
  logic       stream_valid, busy;

  int checks = 0;
  int errors = 0;

  // monitor state
  int         cyc = 0;
  int         rr_cnt = 0, rr_cyc = 0;
  logic [1:0] rr_val = 2'b00;
  int         start_cnt = 0, start_cyc = 0;
  logic [7:0] start_data = 8'h00;
  int         resp_cnt = 0, resp_cyc = 0;
  logic       resp_id_s = 1'b0;
  logic [1:0] resp_st_s = 2'b00;
  logic [7:0] stq[$];

  // bench bookkeeping
  int         rr_taken = 0, resp_taken = 0, last_resp_cyc = -1;
  int         rx_cyc = 0;
  int         mdl_last = 1;
  int         noise_min = 0, noise_max = 0;
  int         plan[$];
  logic [7:0] exp_st[$];

  ps2_cmd_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_status(resp_status),
    .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_ack(tx_ack), .tx_error(tx_error),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .stream_data(stream_data), .stream_valid(stream_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every output event with the cycle it happened in.
  always @(negedge clk) begin
    if (req_ready != 2'b00) begin
      rr_cnt++;
      rr_val = req_ready;
      rr_cyc = cyc;
    end
    if (tx_start) begin
      start_cnt++;
      start_cyc  = cyc;
      start_data = tx_data;
    end
    if (resp_valid) begin
      resp_cnt++;
      resp_cyc  = cyc;
      resp_id_s = resp_id;
      resp_st_s = resp_status;
    end
    if (stream_valid) stq.push_back(stream_data);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    rx_cyc   = cyc;
    tick();
    rx_ready = 1'b0;
  endtask

  function automatic logic [7:0] noise_byte();
    logic [7:0] nb;
    do nb = 8'($urandom); while (nb == 8'hFA || nb == 8'hFC || nb == 8'hFE);
    return nb;
  endfunction

  // Reference model: walk the plan of attempt outcomes with the retry budget.
  function automatic void predict(output int n_att, output int st);
    int retries = 0;
    n_att = 0;
    st    = 1;
    foreach (plan[i]) begin
      n_att++;
      if (plan[i] == O_FA) begin st = 0; return; end
      if (plan[i] == O_FC) begin st = 1; return; end
      if (plan[i] == O_SILENT) begin st = 2; return; end
      if (retries < MR) retries++;
      else begin st = 1; return; end
    end
  endfunction

  task automatic make_plan();
    int n_res, k;
    plan.delete();
    n_res = $urandom_range(0, 3);
    for (int i = 0; i < n_res; i++)
      plan.push_back(($urandom_range(0, 1) == 1) ? O_FE : O_TXERR);
    if (n_res < 3) begin
      k = $urandom_range(0, 9);
      plan.push_back((k < 5) ? O_FA : ((k < 8) ? O_FC : O_SILENT));
    end
  endtask

  // Serve one accepted command for requester id, acting as transmitter and
  // device according to plan, then check response, attempts and stream.
  task automatic serve(input int id, input logic [7:0] data);
    int n_att, exp_status, starts0, grant_cyc, k, outc;
    bit rx_final;
    bit ok;
    logic [1:0] exp_rr;
    logic [7:0] nb;
    predict(n_att, exp_status);
    exp_rr = (id == 1) ? 2'b10 : 2'b01;

    for (int i = 0; i < 20 && rr_cnt == rr_taken; i++) tick();
    checks++;
    if (rr_cnt == rr_taken) begin
      errors++;
      $display("[TB] FAIL grant_wait: no req_ready in 20 cycles, expected %b", exp_rr);
      return;
    end
    rr_taken = rr_cnt;
    checks++;
    if (rr_val !== exp_rr) begin
      errors++;
      $display("[TB] FAIL grant_id: got req_ready %b, expected %b", rr_val, exp_rr);
    end
    checks++;
    if (rr_cyc <= last_resp_cyc) begin
      errors++;
      $display("[TB] FAIL grant_gap: grant cycle %0d, expected after resp cycle %0d", rr_cyc, last_resp_cyc);
    end
    grant_cyc = rr_cyc;
    req_valid[id] = 1'b0;
    starts0  = start_cnt;
    rx_final = 1'b0;

    for (int a = 0; a < n_att; a++) begin
      for (int i = 0; i < 20 && start_cnt == starts0 + a; i++) tick();
      checks++;
      if (start_cnt == starts0 + a) begin
        errors++;
        $display("[TB] FAIL start_wait: attempt %0d got no tx_start, expected one", a);
        return;
      end
      if (a == 0) begin
        checks++;
        if (start_cyc != grant_cyc + 1) begin
          errors++;
          $display("[TB] FAIL start_latency: tx_start cycle %0d, expected %0d", start_cyc, grant_cyc + 1);
        end
      end
      checks++;
      if (start_data !== data) begin
        errors++;
        $display("[TB] FAIL tx_data: attempt %0d got %h, expected %h", a, start_data, data);
      end
      tx_ack   = 1'b0;
      tx_error = 1'b0;
      tx_busy  = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      tx_busy = 1'b0;
      outc = plan[a];
      if (outc == O_TXERR) begin
        tx_error = 1'b1;
        continue;
      end
      tx_ack = 1'b1;
      tick();
      k = $urandom_range(noise_min, noise_max);
      for (int n = 0; n < k; n++) begin
        nb = noise_byte();
        exp_st.push_back(nb);
        send_rx(nb);
      end
      if (outc == O_FA) send_rx(8'hFA);
      else if (outc == O_FC) send_rx(8'hFC);
      else if (outc == O_FE) send_rx(8'hFE);
      if (outc != O_SILENT) rx_final = (a == n_att - 1);
    end

    for (int i = 0; i < 200 && resp_cnt == resp_taken; i++) tick();
    checks++;
    if (resp_cnt == resp_taken) begin
      errors++;
      $display("[TB] FAIL resp_wait: no resp_valid in 200 cycles, expected status %0d", exp_status);
      return;
    end
    resp_taken    = resp_cnt;
    last_resp_cyc = resp_cyc;
    checks++;
    if (resp_id_s !== 1'(id)) begin
      errors++;
      $display("[TB] FAIL resp_id: got %0d, expected %0d", resp_id_s, id);
    end
    checks++;
    if (resp_st_s !== 2'(exp_status)) begin
      errors++;
      $display("[TB] FAIL resp_status: got %b, expected %b", resp_st_s, 2'(exp_status));
    end
    if (exp_status == 2) begin
      checks++;
      if (resp_cyc - start_cyc < TO - 2 || resp_cyc - start_cyc > TO + 3) begin
        errors++;
        $display("[TB] FAIL timeout_delay: resp %0d cycles after tx_start, expected about %0d", resp_cyc - start_cyc, TO);
      end
    end else if (rx_final) begin
      checks++;
      if (resp_cyc != rx_cyc + 1) begin
        errors++;
        $display("[TB] FAIL resp_latency: resp cycle %0d, expected %0d", resp_cyc, rx_cyc + 1);
      end
    end
    checks++;
    if (start_cnt - starts0 != n_att) begin
      errors++;
      $display("[TB] FAIL start_count: got %0d tx_start pulses, expected %0d", start_cnt - starts0, n_att);
    end
    ok = (stq.size() == exp_st.size());
    if (ok) foreach (stq[i]) if (stq[i] !== exp_st[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL stream: got %0d bytes %p, expected %0d bytes %p", stq.size(), stq, exp_st.size(), exp_st);
    end
    stq.delete();
    exp_st.delete();
    mdl_last = id;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    mdl_last = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_data0 = 8'($urandom);
    req_data1 = 8'($urandom);
    rx_ready  = 1'b1;
    rx_data   = 8'h55;
    tick();
    tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rst_req_ready: got %b, expected 00", req_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_tx_start: got %b, expected 0", tx_start); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_valid: got %b, expected 0", resp_valid); end
    checks++; if (resp_id !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_id: got %b, expected 0", resp_id); end
    checks++; if (resp_status !== 2'b00) begin errors++; $display("[TB] FAIL rst_resp_status: got %b, expected 00", resp_status); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_tx_data: got %h, expected 00", tx_data); end
    checks++; if (stream_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_stream_valid: got %b, expected 0", stream_valid); end
    checks++; if (stream_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_stream_data: got %h, expected 00", stream_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b, expected 0", busy); end
    rx_ready  = 1'b0;
    req_valid = 2'b00;
    tick();
    rst_n    = 1'b1;
    mdl_last = 1;
    tick();
    stq.delete();
  endtask

  task automatic test_single();
    noise_min = 0; noise_max = 0;
    plan = '{O_FA};
    req_data0 = 8'hF4;
    req_valid = 2'b01;
    serve(0, 8'hF4);
  endtask

  task automatic test_back_to_back();
    do_reset();
    noise_min = 0; noise_max = 0;
    req_data0 = 8'hFF;
    req_data1 = 8'hE8;
    req_valid = 2'b11;
    plan = '{O_FA};
    serve(0, 8'hFF);
    plan = '{O_FA};
    serve(1, 8'hE8);
  endtask

  task automatic test_retry_exhaust();
    noise_min = 0; noise_max = 1;
    plan = '{O_FE, O_FE, O_FE};
    req_data1 = 8'hED;
    req_valid = 2'b10;
    serve(1, 8'hED);
  endtask

  task automatic test_retry_recover();
    noise_min = 0; noise_max = 0;
    plan = '{O_FE, O_FA};
    req_data0 = 8'hF3;
    req_valid = 2'b01;
    serve(0, 8'hF3);
  endtask

  task automatic test_timeout();
    noise_min = 0; noise_max = 0;
    plan = '{O_SILENT};
    req_data0 = 8'hF2;
    req_valid = 2'b01;
    serve(0, 8'hF2);
  endtask

  task automatic test_stream();
    bit ok;
    noise_min = 1; noise_max = 2;
    plan = '{O_FA};
    req_data1 = 8'h08;
    req_valid = 2'b10;
    serve(1, 8'h08);
    // reply codes seen while idle are ordinary stream bytes
    tick();
    exp_st.push_back(8'hFA); send_rx(8'hFA);
    exp_st.push_back(8'hFE); send_rx(8'hFE);
    tick();
    ok = (stq.size() == exp_st.size());
    if (ok) foreach (stq[i]) if (stq[i] !== exp_st[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL idle_stream: got %p, expected %p", stq, exp_st);
    end
    stq.delete();
    exp_st.delete();
  endtask

  task automatic test_reset_mid_txn();
    int resp0, s0;
    req_data0 = 8'h2A;
    req_valid = 2'b01;
    for (int i = 0; i < 20 && rr_cnt == rr_taken; i++) tick();
    rr_taken  = rr_cnt;
    req_valid = 2'b00;
    s0 = start_cnt;
    for (int i = 0; i < 20 && start_cnt == s0; i++) tick();
    tx_ack = 1'b0; tx_error = 1'b0; tx_busy = 1'b1;
    tick();
    tick();
    tx_busy = 1'b0;
    tx_ack  = 1'b1;
    tick();
    tick();
    req_valid = 2'b10;
    resp0 = resp_cnt;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_busy: got %b, expected 1 before reset", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b, expected 0", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_tx_data: got %h, expected 00", tx_data); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL mid_rst_req_ready: got %b, expected 00", req_ready); end
    req_valid = 2'b00;
    tx_ack    = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
    mdl_last = 1;
    repeat (5) tick();
    checks++;
    if (resp_cnt != resp0) begin
      errors++;
      $display("[TB] FAIL mid_no_resp: got %0d resp_valid pulses, expected 0", resp_cnt - resp0);
    end
    checks++;
    if (rr_cnt != rr_taken) begin
      errors++;
      $display("[TB] FAIL dropped_req: got %0d grants, expected 0", rr_cnt - rr_taken);
    end
    rr_taken = rr_cnt;
    last_resp_cyc = -1;
    stq.delete();
    noise_min = 0; noise_max = 0;
    plan = '{O_FA};
    req_data0 = 8'hF6;
    req_valid = 2'b01;
    serve(0, 8'hF6);
  endtask

  task automatic test_random();
    logic [1:0] pat;
    logic [7:0] d0, d1;
    int first;
    noise_min = 0; noise_max = 2;
    for (int t = 0; t < 10; t++) begin
      pat = 2'($urandom_range(1, 3));
      d0  = 8'($urandom);
      d1  = 8'($urandom);
      tick();
      req_data0 = d0;
      req_data1 = d1;
      req_valid = pat;
      first = (pat == 2'b11) ? (1 - mdl_last) : ((pat == 2'b10) ? 1 : 0);
      make_plan();
      serve(first, (first == 1) ? d1 : d0);
      if (pat == 2'b11) begin
        make_plan();
        serve(1 - first, (first == 1) ? d0 : d1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_data0 = 8'h00;
    req_data1 = 8'h00;
    tx_busy = 1'b0;
    tx_ack = 1'b0;
    tx_error = 1'b0;
    rx_data = 8'h00;
    rx_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_retry_exhaust();
    test_retry_recover();
    test_timeout();
    test_stream();
    test_reset_mid_txn();
    test_random();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, expected to finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ps2_cmd_arbiter.md
PS2_CMD_ARBITER -- requirements
Module: ps2_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 540000, is the per-attempt response timeout in clk cycles (~20 ms at 27 MHz).
REQ-002 Parameter MAX_RETRY, default 2, is the number of re-sends allowed after the first attempt.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid[1:0]  in  2  per-requester command request; index 0 is the init sequencer, index 1 is the UI.
REQ-006 req_data0, req_data1  in  8 each  command byte for requester 0 and 1.
REQ-007 req_ready[1:0]  out  2  one-cycle accept strobe per requester.
REQ-008 resp_valid  out  1  one-cycle completion pulse.
REQ-009 resp_id  out  1  requester that owns resp_valid.
REQ-010 resp_status  out  2  completion code: 00 OK, 01 FAIL, 10 TIMEOUT.
REQ-011 tx_data  out  8  byte to the PS/2 transmitter.
REQ-012 tx_start  out  1  one-cycle start pulse to the transmitter.
REQ-013 tx_busy, tx_ack, tx_error  in  1 each  transmitter status; tx_ack and tx_error hold their level until the next start.
REQ-014 rx_data  in  8  byte from the PS/2 receiver.
REQ-015 rx_ready  in  1  one-cycle receiver valid pulse.
REQ-016 stream_data  out  8  pass-through byte.
REQ-017 stream_valid  out  1  one-cycle pulse accompanying stream_data.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, START, WAIT_TX, WAIT_ACK, RESP.
REQ-020 IDLE, any req_valid high:
- grant one requester and pulse its req_ready for that cycle;
- capture its byte into tx_data; clear retry_cnt;
- go to START.
REQ-021 Arbitration: round-robin on last_grant.
- Only one request valid: that requester wins.
- Both valid: the requester not granted last wins.
REQ-022 START: assert tx_start for exactly one cycle, load the timeout counter with TIMEOUT_CYCLES, go to WAIT_TX.
REQ-023 WAIT_TX: ignore tx_busy in the first cycle after START. Exit on the first later cycle with tx_busy=0:
- tx_ack=1: go to WAIT_ACK;
- tx_error=1: treat as a resend request (REQ-025).
REQ-024 WAIT_ACK, rx_ready high, byte is consumed and not forwarded:
- 0xFA: status OK;
- 0xFC: status FAIL;
- 0xFE: resend (REQ-025).
REQ-025 Resend:
- retry_cnt < MAX_RETRY: increment retry_cnt, go to START with the same tx_data;
- otherwise: status FAIL, go to RESP.
REQ-026 Timeout counter:
- decrements by one each cycle in WAIT_TX and WAIT_ACK;
- reaching 0 sets status TIMEOUT and goes to RESP, with no retry;
- if timeout and a consuming rx byte occur in the same cycle, the rx byte wins.
REQ-027 RESP:
- pulse resp_valid for one cycle with resp_id = granted requester and resp_status set;
- update last_grant; go to IDLE.
A new grant happens no earlier than the next cycle.
REQ-028 rx bytes are forwarded to stream_data/stream_valid in the same cycle as rx_ready, except the 0xFA/0xFC/0xFE bytes consumed in WAIT_ACK. Any other byte received in WAIT_ACK is forwarded.
REQ-029 Requesters hold req_valid and data until req_ready. A req_valid deasserted before grant is dropped with no response.
REQ-030 Latency for a single request from IDLE:
- req_ready in cycle N;
- tx_start in cycle N+1;
- resp_valid in the cycle after the consuming rx byte.
REQ-031 retry_cnt is wide enough to hold MAX_RETRY. The timeout counter is 32 bits.

Reset
REQ-032 While rst_n is low, regardless of clk:
- state=IDLE, last_grant=1 (requester 0 wins first);
- retry_cnt=0, timeout counter=0, tx_data=0x00;
- tx_start=0, req_ready=00, resp_valid=0, resp_id=0, resp_status=00;
- stream_valid=0, stream_data=0x00, busy=0.
REQ-033 Reset asserted mid-transaction abandons that transaction with no resp_valid. After release, the block restarts in IDLE.

Verification
REQ-034 req0=0xF4 alone; transmitter acks; rx 0xFA.
-> req_ready=01 in cycle N, tx_start in N+1, resp_valid with id 0 and status 00, no stream_valid.
REQ-035 Both requesters valid together from reset, 0xFF and 0xE8.
-> req0 granted first; after its RESP, req1 granted; tx_data sequence 0xFF then 0xE8.
REQ-036 rx 0xFE three times with MAX_RETRY=2.
-> exactly 3 tx_start pulses, then resp_status 01.
REQ-037 rx 0xFE once, then 0xFA.
-> 2 tx_start pulses, then resp_status 00.
REQ-038 TIMEOUT_CYCLES=100, no rx after tx_ack.
-> resp_status 10 about 100 cycles after tx_start.
REQ-039 rx 0x08 during WAIT_ACK, then 0xFA.
-> stream_valid with 0x08, then resp OK.
REQ-040 rst_n low during WAIT_ACK.
-> outputs return to reset values, no resp_valid, next request proceeds normally.
